// File: rtl/prefetch.sv
// prefetch: instruction prefetch queue sitting between the fetch stage and the icache.
// Keeps one icache read in flight at most and buffers returned words as {pc, instr}.
// Optional feature macro: PF_BYPASS_EN (same-cycle forwarding of a response into an empty queue).
`ifndef PC_RESET
`define PC_RESET 32'h8000_0000
`endif
`ifndef INSTR_NOP
`define INSTR_NOP 32'h0000_0013
`endif

module prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = `PC_RESET
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if2pf_pc_i,
  input  logic        if2pf_instr_req_i,
  input  logic        if2pf_clear_i,
  output logic        pf2if_ack_o,
  output logic [31:0] pf2if_rdata_o,
  output logic        pf2if_stall_o,
  output logic        pf2icache_req_o,
  output logic [31:0] pf2icache_addr_o,
  output logic        pf2icache_kill_o,
  input  logic        icache2pf_ack_i,
  input  logic [31:0] icache2pf_rdata_i
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_KILL = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [31:0]     r_q_pc    [DEPTH];
  logic [31:0]     r_q_instr [DEPTH];
  logic [AW-1:0]   r_rd;
  logic [AW-1:0]   r_wr;
  logic [CW-1:0]   r_count;
  logic [31:0]     r_fa;
  logic            r_mismatch;

  logic            w_nonempty;
  logic            w_hit;
  logic            w_mismatch;
  logic            w_clr;
  logic            w_resp;
  logic            w_byp;
  logic            w_ack;
  logic            w_pop;
  logic            w_push;
  logic [31:0]     w_head_pc;
  logic [31:0]     w_head_instr;

  // Head lookup, flush sources and queue handshakes
  always_comb begin
    w_head_pc    = r_q_pc[r_rd];
    w_head_instr = r_q_instr[r_rd];
    w_nonempty   = (r_count != '0);
    w_hit        = w_nonempty && (w_head_pc == if2pf_pc_i);
    // a wrong-path head is flushed one cycle later, once
    w_mismatch   = w_nonempty && !w_hit && !if2pf_clear_i && !r_mismatch;
    w_clr        = if2pf_clear_i || r_mismatch;
    w_resp       = (r_state == S_WAIT) && icache2pf_ack_i && !w_clr;
`ifdef PF_BYPASS_EN
    w_byp        = w_resp && !w_nonempty && (r_fa == if2pf_pc_i);
`else
    w_byp        = 1'b0;
`endif
    w_ack        = (w_hit && !if2pf_clear_i) || w_byp;
    w_pop        = w_hit && !if2pf_clear_i && if2pf_instr_req_i;
    // a bypassed word consumed this cycle is not stored
    w_push       = w_resp && !(w_byp && if2pf_instr_req_i);
  end

  // Fetch-stage facing outputs
  always_comb begin
    pf2if_ack_o   = w_ack;
    pf2if_stall_o = !w_ack && !if2pf_clear_i;
    if (w_byp)      pf2if_rdata_o = icache2pf_rdata_i;
    else if (w_ack) pf2if_rdata_o = w_head_instr;
    else            pf2if_rdata_o = `INSTR_NOP;
  end

  // Queue storage: word written at the tail on every accepted response
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_wr]    <= r_fa;
      r_q_instr[r_wr] <= icache2pf_rdata_i;
    end
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst || w_clr) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

  // Fetch address and deferred-flush flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fa       <= {RESET_PC[31:2], 2'b00};
      r_mismatch <= 1'b0;
    end else begin
      r_mismatch <= w_mismatch;
      if (w_clr)       r_fa <= {if2pf_pc_i[31:2], 2'b00};
      else if (w_resp) r_fa <= r_fa + 32'd4;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state: a request is only launched while the queue has room
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (!w_clr && (r_count < CW'(DEPTH))) w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_clr)                w_state_nxt = S_KILL;
        else if (icache2pf_ack_i) w_state_nxt = S_IDLE;
      end
      S_KILL:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs towards the icache
  always_comb begin
    pf2icache_req_o  = (r_state == S_WAIT);
    pf2icache_kill_o = (r_state == S_KILL);
    pf2icache_addr_o = r_fa;
  end

endmodule

// File: tb/tb_prefetch.sv
// tb_prefetch: directed bench for prefetch with a queue-level reference model.
`ifndef PC_RESET
`define PC_RESET 32'h8000_0000
`endif
`ifndef INSTR_NOP
`define INSTR_NOP 32'h0000_0013
`endif

module tb_prefetch;
  localparam int unsigned DEPTH       = 4;
  localparam logic [31:0] TB_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] TB_NOP      = `INSTR_NOP;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        instr_req;
  logic        clear_i;
  logic        ack_o;
  logic [31:0] rdata_o;
  logic        stall_o;
  logic        req_o;
  logic [31:0] addr_o;
  logic        kill_o;
  logic        ack_i;
  logic [31:0] rdata_i;

  int n_chk  = 0;
  int n_pass = 0;

  // stimulus-side state
  logic        auto_ack;
  logic        follow;
  logic        req_prev;
  logic [31:0] got[$];
  int          cyc;
  int          t_acki;
  int          t_acko;
  int          k;

  // reference model state
  logic [31:0] mq_pc[$];
  logic [31:0] mq_in[$];
  logic [31:0] m_fa;
  logic        m_pend;
  logic        m_live = 1'b0;
  logic        m_empty, m_hit, m_clr, m_acc, m_byp, m_ack, m_mis;
  logic [31:0] m_rd;

  prefetch #(.DEPTH(DEPTH), .RESET_PC(TB_RESET_PC)) dut (
    .clk               (clk),
    .rst               (rst),
    .if2pf_pc_i        (pc_i),
    .if2pf_instr_req_i (instr_req),
    .if2pf_clear_i     (clear_i),
    .pf2if_ack_o       (ack_o),
    .pf2if_rdata_o     (rdata_o),
    .pf2if_stall_o     (stall_o),
    .pf2icache_req_o   (req_o),
    .pf2icache_addr_o  (addr_o),
    .pf2icache_kill_o  (kill_o),
    .icache2pf_ack_i   (ack_i),
    .icache2pf_rdata_i (rdata_i)
  );

  always #5 clk = ~clk;

  // icache contents: low half of the address tagged with 0xC0DE
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], 16'hC0DE};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
  endtask

  // one clock: sample at negedge, drive just after posedge
  task automatic tick();
    logic fire;
    @(negedge clk);
    fire = ack_o && instr_req;
    if (fire) got.push_back(rdata_o);
    if (ack_i && t_acki < 0) t_acki = cyc;
    if (ack_o && t_acko < 0) t_acko = cyc;
    @(posedge clk);
    #1;
    cyc++;
    if (follow && fire) pc_i = pc_i + 32'd4;
    if (auto_ack) begin
      ack_i   = req_o && req_prev && !ack_i;
      rdata_i = mem(addr_o);
    end else begin
      ack_i = 1'b0;
    end
    req_prev = req_o;
  endtask

  task automatic do_reset();
    auto_ack  = 1'b0;
    follow    = 1'b0;
    instr_req = 1'b0;
    clear_i   = 1'b0;
    ack_i     = 1'b0;
    rst       = 1'b1;
    tick();
    tick();
    rst      = 1'b0;
    req_prev = 1'b0;
    got.delete();
  endtask

  // Reference model: a plain FIFO of {pc, word}, the fetch address, and a pending flush
  always @(negedge clk) begin
    if (rst) begin
      mq_pc.delete();
      mq_in.delete();
      m_fa   = TB_RESET_PC;
      m_pend = 1'b0;
      m_live = 1'b1;
    end else if (m_live) begin
      m_empty = (mq_pc.size() == 0);
      m_hit   = !m_empty && (mq_pc[0] == pc_i);
      m_clr   = clear_i || m_pend;
      m_acc   = ack_i && req_o && !m_clr;
      m_byp   = 1'b0;
`ifdef PF_BYPASS_EN
      m_byp   = m_acc && m_empty && (m_fa == pc_i);
`endif
      m_ack   = (m_hit && !clear_i) || m_byp;
      if (!m_ack)     m_rd = TB_NOP;
      else if (m_byp) m_rd = rdata_i;
      else            m_rd = mq_in[0];
      chk("cyc_ack",   32'(ack_o),   32'(m_ack));
      chk("cyc_rdata", rdata_o,      m_rd);
      chk("cyc_stall", 32'(stall_o), 32'(!m_ack && !clear_i));
      chk("cyc_count", 32'(dut.r_count), 32'(mq_pc.size()));
      if (req_o) begin
        chk("cyc_addr", addr_o, m_fa);
        chk("cyc_room", 32'(mq_pc.size() < DEPTH), 32'd1);
      end
      m_mis = !m_empty && !m_hit && !clear_i && !m_pend;
      if (m_clr) begin
        mq_pc.delete();
        mq_in.delete();
        m_fa = {pc_i[31:2], 2'b00};
      end else begin
        if (m_ack && instr_req && !m_empty) begin
          void'(mq_pc.pop_front());
          void'(mq_in.pop_front());
        end
        if (m_acc) begin
          if (!(m_byp && instr_req)) begin
            mq_pc.push_back(m_fa);
            mq_in.push_back(rdata_i);
          end
          m_fa = m_fa + 32'd4;
        end
      end
      m_pend = m_mis;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got 0 want 1");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; pc_i = TB_RESET_PC; instr_req = 1'b0; clear_i = 1'b0;
    ack_i = 1'b0; rdata_i = '0; auto_ack = 1'b0; follow = 1'b0;
    req_prev = 1'b0; cyc = 0; t_acki = -1; t_acko = -1;

    // reset values
    do_reset();
    #1;
    chk("rst_req",   32'(req_o),   32'd0);
    chk("rst_kill",  32'(kill_o),  32'd0);
    chk("rst_ack",   32'(ack_o),   32'd0);
    chk("rst_stall", 32'(stall_o), 32'd1);
    chk("rst_rdata", rdata_o,      32'h0000_0013);

    // stray ack while idle is ignored
    ack_i = 1'b1; rdata_i = 32'h1234_5678;
    tick(); #1;
    chk("stray_ack_count", 32'(dut.r_count), 32'd0);

    // streaming fetch from reset pc
    do_reset();
    pc_i = TB_RESET_PC; instr_req = 1'b1; auto_ack = 1'b1; follow = 1'b1;
    t_acki = -1; t_acko = -1;
    k = 0;
    while (got.size() < 3 && k < 40) begin tick(); k++; end
    chk("stream_words", 32'(got.size()), 32'd3);
    if (got.size() >= 3) begin
      chk("stream_w0", got[0], 32'h0000_C0DE);
      chk("stream_w1", got[1], 32'h0004_C0DE);
      chk("stream_w2", got[2], 32'h0008_C0DE);
    end
`ifdef PF_BYPASS_EN
    chk("stream_latency", 32'(t_acko - t_acki), 32'd0);
`else
    chk("stream_latency", 32'(t_acko - t_acki), 32'd1);
`endif

    // fill without consuming, then drain
    do_reset();
    pc_i = TB_RESET_PC; auto_ack = 1'b1; follow = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    #1;
    chk("fill_count", 32'(dut.r_count), 32'd4);
    chk("fill_req",   32'(req_o),       32'd0);
    chk("fill_head",  rdata_o,          32'h0000_C0DE);
    got.delete();
    instr_req = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    instr_req = 1'b0;
    chk("drain_words", 32'(got.size()), 32'd4);
    if (got.size() >= 4) begin
      chk("drain_w0", got[0], 32'h0000_C0DE);
      chk("drain_w3", got[3], 32'h000C_C0DE);
    end

    // push+pop at count 2, then fill to full
    do_reset();
    pc_i = TB_RESET_PC; auto_ack = 1'b1; follow = 1'b1;
    k = 0;
    while (!(dut.r_count == 2 && ack_i) && k < 60) begin tick(); k++; end
    chk("pp_reach", 32'(dut.r_count == 2 && ack_i), 32'd1);
    instr_req = 1'b1;
    tick();
    instr_req = 1'b0;
    #1;
    chk("pp_count2", 32'(dut.r_count), 32'd2);
    k = 0;
    while (!ack_i && k < 20) begin tick(); k++; end
    tick(); #1;
    chk("pp_count3", 32'(dut.r_count), 32'd3);
    k = 0;
    while (!ack_i && k < 20) begin tick(); k++; end
    tick(); #1;
    chk("pp_count4", 32'(dut.r_count), 32'd4);
    tick(); tick(); tick(); #1;
    chk("pp_full_req", 32'(req_o), 32'd0);

    // explicit clear while a request is outstanding, with a colliding ack
    do_reset();
    pc_i = TB_RESET_PC;
    k = 0;
    while (!req_o && k < 10) begin tick(); k++; end
    chk("clr_wait_req", 32'(req_o), 32'd1);
    clear_i = 1'b1; pc_i = 32'h8000_0102; ack_i = 1'b1; rdata_i = 32'hDEAD_BEEF;
    tick();
    clear_i = 1'b0; pc_i = 32'h8000_0100;
    #1;
    chk("clr_kill",  32'(kill_o),      32'd1);
    chk("clr_count", 32'(dut.r_count), 32'd0);
    chk("clr_req",   32'(req_o),       32'd0);
    tick(); #1;
    chk("clr_kill_end", 32'(kill_o), 32'd0);
    k = 0;
    while (!req_o && k < 10) begin tick(); k++; end
    chk("clr_addr", addr_o, 32'h8000_0100);
    auto_ack = 1'b1; instr_req = 1'b1; follow = 1'b1; got.delete();
    k = 0;
    while (got.size() == 0 && k < 20) begin tick(); k++; end
    chk("clr_word", (got.size() > 0) ? got[0] : 32'h0, 32'h0100_C0DE);

    // head mismatch acts as a delayed flush
    do_reset();
    pc_i = TB_RESET_PC; auto_ack = 1'b1; follow = 1'b1;
    k = 0;
    while (dut.r_count != 4 && k < 40) begin tick(); k++; end
    instr_req = 1'b1;
    k = 0;
    while (pc_i != 32'h8000_0008 && k < 20) begin tick(); k++; end
    pc_i = 32'h8000_0040;
    #1;
    chk("mis_ack",   32'(ack_o),   32'd0);
    chk("mis_stall", 32'(stall_o), 32'd1);
    tick(); tick(); #1;
    chk("mis_count", 32'(dut.r_count), 32'd0);
    got.delete();
    k = 0;
    while (!req_o && k < 10) begin tick(); k++; end
    chk("mis_addr", addr_o, 32'h8000_0040);
    k = 0;
    while (got.size() == 0 && k < 20) begin tick(); k++; end
    chk("mis_word", (got.size() > 0) ? got[0] : 32'h0, 32'h0040_C0DE);

`ifdef PF_BYPASS_EN
    // same-cycle forwarding into an empty queue
    do_reset();
    pc_i = TB_RESET_PC; instr_req = 1'b1; follow = 1'b1;
    k = 0;
    while (!req_o && k < 10) begin tick(); k++; end
    ack_i = 1'b1; rdata_i = 32'h0000_0013;
    #1;
    chk("byp_ack",   32'(ack_o), 32'd1);
    chk("byp_rdata", rdata_o,    32'h0000_0013);
    tick(); #1;
    chk("byp_count", 32'(dut.r_count), 32'd0);
`endif

    instr_req = 1'b0; auto_ack = 1'b0;
    tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
